// File: rtl/axo_mem_rr_arbiter_if.sv
// Bus bundle between N memory requesters, the round-robin arbiter and one shared target.
// The slave view belongs to the arbiter; the master view is the surrounding requesters plus target.
interface axo_mem_rr_arbiter_if #(
    parameter int unsigned ports = 2,
    parameter int unsigned alen  = 32,
    parameter int unsigned dlen  = 32
);
    logic [ports-1:0]          req_re;
    logic [ports-1:0]          req_we;
    logic [ports*alen-1:0]     req_addr;
    logic [ports*dlen-1:0]     req_wdata;
    logic [ports*dlen/8-1:0]   req_wmask;
    logic [ports-1:0]          req_ready;
    logic [dlen-1:0]           req_rdata;
    logic                      req_err;

    logic                      mem_re;
    logic                      mem_we;
    logic [alen-1:0]           mem_addr;
    logic [dlen-1:0]           mem_wdata;
    logic [dlen/8-1:0]         mem_wmask;
    logic                      mem_ready;
    logic [dlen-1:0]           mem_rdata;

    modport slave (
        input  req_re, req_we, req_addr, req_wdata, req_wmask, mem_ready, mem_rdata,
        output req_ready, req_rdata, req_err, mem_re, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_re, req_we, req_addr, req_wdata, req_wmask, mem_ready, mem_rdata,
        input  req_ready, req_rdata, req_err, mem_re, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/axo_mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory target among several requesters, one
// transaction in flight, request latched at grant, optional per-transaction timeout.
module axo_mem_rr_arbiter #(
    parameter int unsigned ports   = 2,
    parameter int unsigned alen    = 32,
    parameter int unsigned dlen    = 32,
    parameter int unsigned timeout = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    axo_mem_rr_arbiter_if.slave  bus,
    output logic [ports-1:0]     grant,
    output logic                 busy
);
    localparam int unsigned MW = dlen / 8;
    localparam int unsigned PW = (ports > 1) ? $clog2(ports) : 1;
    localparam int unsigned CW = (timeout > 1) ? $clog2(timeout) : 1;
    localparam bit             TO_EN   = (timeout != 0);
    localparam logic [CW-1:0]  TO_LAST = CW'((timeout > 0) ? timeout - 1 : 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_last;
    logic [CW-1:0]      r_cnt;
    logic [ports-1:0]   r_grant;
    logic               r_busy;
    logic               r_mem_re;
    logic               r_mem_we;
    logic [alen-1:0]    r_mem_addr;
    logic [dlen-1:0]    r_mem_wdata;
    logic [MW-1:0]      r_mem_wmask;

    logic [ports-1:0]   w_req;
    logic               w_found;
    logic [PW-1:0]      w_win;
    int                 w_idx;
    logic               w_hit;
    logic               w_done;

    // First requester found scanning cyclically from the one after the last winner.
    always_comb begin
        w_req   = bus.req_re | bus.req_we;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= int'(ports); k++) begin
            w_idx = (int'(r_last) + k) % int'(ports);
            if (!w_found && w_req[PW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    // A coincident mem_ready takes priority over the timeout, and reset suppresses completion.
    always_comb begin
        w_hit  = TO_EN && (r_cnt == TO_LAST);
        w_done = r_busy && !rst && (bus.mem_ready || w_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= PW'(ports - 1);
            r_cnt       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_BUSY;
                        r_busy      <= 1'b1;
                        r_last      <= w_win;
                        r_cnt       <= '0;
                        r_grant     <= ports'(1) << w_win;
                        r_mem_re    <= bus.req_re[w_win];
                        r_mem_we    <= bus.req_we[w_win];
                        r_mem_addr  <= bus.req_addr[w_win*alen +: alen];
                        r_mem_wdata <= bus.req_wdata[w_win*dlen +: dlen];
                        r_mem_wmask <= bus.req_wmask[w_win*MW +: MW];
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_grant  <= '0;
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_re    = r_mem_re;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wmask = r_mem_wmask;
    assign grant         = r_grant;
    assign busy          = r_busy;

    // Completion signalling is combinational so the requester sees it in the target's ready cycle.
    assign bus.req_ready = w_done ? r_grant : '0;
    assign bus.req_err   = w_done && !bus.mem_ready;
    assign bus.req_rdata = (w_done && bus.mem_ready) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_axo_mem_rr_arbiter.sv
// Directed bench for axo_mem_rr_arbiter: two requesters, timeout of 4 cycles.
module tb_axo_mem_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       busy;
    int         errors = 0;
    int         checks = 0;

    axo_mem_rr_arbiter_if #(.ports(2), .alen(32), .dlen(32)) bus ();

    axo_mem_rr_arbiter #(.ports(2), .alen(32), .dlen(32), .timeout(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_re    = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if ({bus.mem_re, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {bus.mem_re, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 68'h0) begin errors++; $display("FAIL rst_membus: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.mem_wmask}); end
        checks++; if ({bus.req_ready, bus.req_err} !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b want 000", {bus.req_ready, bus.req_err}); end
        checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.req_rdata); end
    endtask

    task automatic test_single_read();
        step();
        bus.req_re    = 2'b01;
        bus.req_addr  = 64'h0000_0000_0000_0404;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({busy, bus.req_ready, bus.req_rdata} !== 35'h0) begin errors++; $display("FAIL rd_idle: got busy=%b ready=%b rdata=%h want 0", busy, bus.req_ready, bus.req_rdata); end
        step();
        bus.req_re = 2'b00;
        @(negedge clk);
        checks++; if ({bus.mem_re, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got %b want 10", {bus.mem_re, bus.mem_we}); end
        checks++; if (bus.mem_addr !== 32'h404) begin errors++; $display("FAIL rd_addr: got %h want 404", bus.mem_addr); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", grant); end
        checks++; if ({bus.req_ready, bus.req_err} !== 3'b010) begin errors++; $display("FAIL rd_ready: got %b want 010", {bus.req_ready, bus.req_err}); end
        checks++; if (bus.req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", bus.req_rdata); end
        step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({busy, bus.mem_re, grant, bus.req_ready} !== 6'b0) begin errors++; $display("FAIL rd_done: got busy=%b re=%b grant=%b ready=%b want 0", busy, bus.mem_re, grant, bus.req_ready); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [8];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_re    = 2'b11;
        bus.req_addr  = 64'h0000_0200_0000_0100;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g[i]); end
            checks++; if (bus.req_ready !== exp_g[i]) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.req_ready, exp_g[i]); end
            if (exp_g[i] != 2'b00) begin
                checks++;
                if (bus.mem_addr !== ((exp_g[i] == 2'b01) ? 32'h100 : 32'h200)) begin
                    errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, bus.mem_addr, (exp_g[i] == 2'b01) ? 32'h100 : 32'h200);
                end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_latching();
        bus.req_we    = 2'b10;
        bus.req_addr  = 64'h0000_0800_0000_0000;
        bus.req_wdata = 64'h1234_5678_0000_0000;
        bus.req_wmask = 8'hF0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got busy=%b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) bus.req_addr = 64'h0;
            if (i == 2) bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++; if (bus.mem_addr !== 32'h800) begin errors++; $display("FAIL wr_addr[%0d]: got %h want 800", i, bus.mem_addr); end
            checks++; if (bus.req_ready !== ((i == 2) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL wr_ready[%0d]: got %b want %b", i, bus.req_ready, (i == 2) ? 2'b10 : 2'b00); end
        end
        checks++; if ({bus.mem_re, bus.mem_we, grant} !== 4'b0110) begin errors++; $display("FAIL wr_strobe: got %b want 0110", {bus.mem_re, bus.mem_we, grant}); end
        checks++; if ({bus.mem_wdata, bus.mem_wmask} !== 36'h12345678F) begin errors++; $display("FAIL wr_data: got %h want 12345678f", {bus.mem_wdata, bus.mem_wmask}); end
        checks++; if (bus.req_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", bus.req_err); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if ({busy, bus.mem_we, bus.req_ready} !== 4'b0) begin errors++; $display("FAIL wr_done: got busy=%b we=%b ready=%b want 0", busy, bus.mem_we, bus.req_ready); end
    endtask

    task automatic test_timeout();
        bus.req_re    = 2'b01;
        bus.req_addr  = 64'h0000_0000_0000_0040;
        bus.mem_rdata = 32'hCAFEF00D;
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge clk);
            checks++; if ({bus.req_ready, bus.req_err} !== ((i == 4) ? 3'b011 : 3'b000)) begin errors++; $display("FAIL to_ready[%0d]: got %b want %b", i, {bus.req_ready, bus.req_err}, (i == 4) ? 3'b011 : 3'b000); end
            checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata[%0d]: got %h want 0", i, bus.req_rdata); end
        end
        step();
        bus.req_re = 2'b00;
        @(negedge clk);
        checks++; if ({busy, bus.mem_re} !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", {busy, bus.mem_re}); end

        bus.req_re   = 2'b10;
        bus.req_addr = 64'h0000_0080_0000_0000;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++; if ({bus.req_ready, bus.req_err} !== ((i == 4) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL tie_ready[%0d]: got %b want %b", i, {bus.req_ready, bus.req_err}, (i == 4) ? 3'b100 : 3'b000); end
            checks++; if (bus.req_rdata !== ((i == 4) ? 32'hCAFEF00D : 32'h0)) begin errors++; $display("FAIL tie_rdata[%0d]: got %h want %h", i, bus.req_rdata, (i == 4) ? 32'hCAFEF00D : 32'h0); end
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_busy();
        bus.req_re   = 2'b01;
        bus.req_addr = 64'h0000_0000_0000_0500;
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_grant: got %b want 01", grant); end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rm_noready: got %b want 00", bus.req_ready); end
        step();
        rst          = 1'b0;
        bus.req_re   = 2'b11;
        bus.req_addr = 64'h0000_0600_0000_0500;
        @(negedge clk);
        checks++; if ({bus.mem_re, busy, grant} !== 4'b0000) begin errors++; $display("FAIL rm_abort: got %b want 0000", {bus.mem_re, busy, grant}); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_regrant: got %b want 01", grant); end
        checks++; if (bus.mem_addr !== 32'h500) begin errors++; $display("FAIL rm_addr: got %h want 500", bus.mem_addr); end
        bus.mem_ready = 1'b1;
        step();
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_latching();
        test_timeout();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axo_mem_rr_arbiter.md
Name: axo_mem_rr_arbiter

Overview:
- Round-robin arbiter that shares a single memory-bus target port among `ports` requesters. Typical use: the CPU instruction and data ports sharing one RAM, or several masters in front of the crossbar.
- One transaction is outstanding at a time. Request signals are latched at grant. A per-transaction timeout terminates a hung target with an error response.

Parameters:
ports, 2, number of requesters (2..8)
alen, 32, address width
dlen, 32, data width (multiple of 8)
timeout, 255, max cycles in BUSY before forced error completion; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
req_re  in  ports  read strobe per requester
req_we  in  ports  write strobe per requester
req_addr  in  ports*alen  address; requester i at bits [i*alen +: alen]
req_wdata  in  ports*dlen  write data, packed as above
req_wmask  in  ports*dlen/8  byte write enables, packed as above
req_ready  out  ports  one-cycle completion pulse to the granted requester
req_rdata  out  dlen  read data, broadcast; valid only when qualified by req_ready
req_err  out  1  qualifies req_ready: 1 = timeout error
mem_re  out  1  read strobe to target
mem_we  out  1  write strobe to target
mem_addr  out  alen  address to target
mem_wdata  out  dlen  write data to target
mem_wmask  out  dlen/8  byte enables to target
mem_ready  in  1  target completion
mem_rdata  in  dlen  target read data
grant  out  ports  one-hot owner of current transaction; 0 when idle
busy  out  1  1 while in BUSY

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high on `rst`.
  - Reset values: state=IDLE, grant=0, busy=0, mem_re=mem_we=0, mem_addr/wdata/wmask=0, req_ready=0, req_err=0, timeout counter=0, last-winner pointer=ports-1 (so port 0 wins first).
- Request definition: requester i is requesting when req_re[i]|req_we[i].
- IDLE state:
  - If any requester is requesting, the winner is the first requesting index scanning cyclically from last+1.
  - On the next edge: latch the winner's re/we/addr/wdata/wmask into the mem_* registers, set grant=onehot(winner), set last=winner, clear the counter, go to BUSY.
  - req_ready=0 throughout IDLE. mem_ready is ignored in IDLE.
- BUSY state:
  - mem_* outputs hold their latched values. Requester-side changes, including withdrawal of the request, do not affect the target.
  - Normal completion: when mem_ready=1, combinationally req_ready[g]=1, req_err=0, req_rdata=mem_rdata in the same cycle. On the next edge: state=IDLE, mem_re=mem_we=0, grant=0.
  - Counting: while mem_ready=0, the counter increments each cycle.
  - Timeout: when timeout!=0 and the counter==timeout-1 with mem_ready=0, that cycle gives req_ready[g]=1, req_err=1, req_rdata=0. Next state is IDLE with strobes dropped.
  - Simultaneous mem_ready and timeout: treated as normal completion (err=0).
- Shared-output rules:
  - req_rdata=0 whenever no req_ready bit is set.
  - Both re and we set: forwarded unchanged; the target defines the semantics.
- Requester obligations:
  - Keep the request asserted until its ready pulse.
  - A request still asserted in the cycle after its ready pulse is treated as a new request.
  - The pointer has already advanced, so other pending requesters win first. This guarantees fairness: each requesting port waits at most ports-1 transactions.
- Latency: a request first seen in IDLE at cycle N gives strobes at N+1. With a zero-wait target, req_ready is at N+1 and the strobe is low at N+2. Minimum 2 cycles per transaction.
- Reset mid-transaction: the transaction is aborted; no req_ready pulse is issued and mem strobes drop on the reset edge.

Test Plan:
- Reset then single read: port 0 re, addr 0x404; target returns 0xDEADBEEF with zero wait -> mem_re at N+1, req_ready=01 with rdata 0xDEADBEEF at N+1, busy low at N+2.
- Contention: ports 0 and 1 request continuously (ports=2), zero-wait target -> grants alternate 01,10,01,10 over 8 cycles; no port served twice in a row.
- Latching: port 1 write addr 0x800, wdata 0x12345678, wmask 0xF; requester changes addr to 0 after grant; target waits 3 cycles -> mem_addr stays 0x800 for all 3 cycles, req_ready[1] is a single pulse.
- Timeout: timeout=4, target never responds -> req_ready pulse with req_err=1 and rdata 0 on the 4th BUSY cycle, then IDLE; mem_ready asserted on that same cycle instead -> err=0, rdata=mem_rdata.
- Reset mid-BUSY: assert rst on the 2nd wait cycle -> no req_ready pulse, mem_re=0 next cycle, next arbitration grants port 0 first.
